// File: rtl/agc_pkg.sv
// Shared definitions for the AGC gain sequencer: default gain width,
// thermometer width and the sequencer state encoding.
package agc_pkg;

  localparam int GAIN_W_DEF  = 6;
  localparam int THERM_W_DEF = 2 ** GAIN_W_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } agc_state_t;

endpackage

// File: rtl/agc_therm_dec.sv
// Binary gain code to thermometer VGA control word: bit i = (i < gain).
// Purely combinational; the sequencer registers the result.
module agc_therm_dec
  import agc_pkg::*;
#(
  parameter int GAIN_W = GAIN_W_DEF
) (
  input  logic [GAIN_W-1:0]    gain,
  output logic [2**GAIN_W-1:0] therm
);

  // One comparator per output bit against the binary code.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    therm = '0;
    for (int i = 0; i < 2 ** GAIN_W; i++) begin
      therm[i] = (GAIN_W'(i) < gain);
    end
  end

endmodule

// File: rtl/agc_gain_sequencer.sv
// AGC gain sequencer: MSB-first successive-approximation search of the VGA
// gain code against the overload comparator, then holds the locked code.
// ext_mode forces a manual gain in any state.
// Optional macro AGC_TRACK_EN adds slow +/-1 tracking while in HOLD.
module agc_gain_sequencer
  import agc_pkg::*;
#(
  parameter int GAIN_W        = GAIN_W_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int REACQ_PERIOD  = 256,
  parameter int UP_HOLDOFF    = 4
) (
  input  logic                 clk,
  input  logic                 RESETn,
  input  logic                 start,
  input  logic                 overload,
  input  logic                 ext_mode,
  input  logic [GAIN_W-1:0]    ext_gain,
  output logic [GAIN_W-1:0]    gain_code,
  output logic [2**GAIN_W-1:0] vga_control,
  output logic                 busy,
  output logic                 done,
  output logic                 gain_changed
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GAIN_W-1:0] MSB      = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [GAIN_W-1:0] LSB      = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [CNT_W-1:0]  SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  agc_state_t          state, state_n;
  logic [GAIN_W-1:0]   gain_n, mask, mask_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                busy_n, done_n;
  logic [2**GAIN_W-1:0] therm_n;

`ifdef AGC_TRACK_EN
  localparam int PER_W   = $clog2(REACQ_PERIOD);
  localparam int CLEAN_W = $clog2(UP_HOLDOFF + 1);
  logic [PER_W-1:0]   period_cnt, period_n;
  logic [CLEAN_W-1:0] clean_cnt, clean_n;
  logic               changed_n;
`else
  // Tracking parameters only matter when tracking is built in.
  logic unused_cfg;
  assign unused_cfg   = (REACQ_PERIOD > 1) & (UP_HOLDOFF > 0);
  assign gain_changed = 1'b0;
`endif

  // vga_control is registered from the decoded next gain so it always matches gain_code.
  agc_therm_dec #(.GAIN_W(GAIN_W)) u_therm_dec (
    .gain  (gain_n),
    .therm (therm_n)
  );

  // Next-state and next-output logic: ext_mode, then start, then per-state behaviour.
  always_comb begin
    state_n = state;
    gain_n  = gain_code;
    mask_n  = mask;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = done;
`ifdef AGC_TRACK_EN
    period_n  = period_cnt;
    clean_n   = clean_cnt;
    changed_n = 1'b0;
`endif

    if (ext_mode) begin
      state_n = IDLE;
      gain_n  = ext_gain;
      mask_n  = '0;
      cnt_n   = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else if (start) begin
      state_n = SEARCH;
      gain_n  = MSB;
      mask_n  = MSB;
      cnt_n   = SETTLE_RELOAD;
      busy_n  = 1'b1;
      done_n  = 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            // Settled: drop the trial bit if this gain overloads.
            if (overload) gain_n = gain_code & ~mask;
            if (mask == LSB) begin
              state_n = HOLD;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              mask_n = mask >> 1;
              gain_n = gain_n | (mask >> 1);
              cnt_n  = SETTLE_RELOAD;
            end
          end
        end
        HOLD: begin
`ifdef AGC_TRACK_EN
          if (period_cnt == PER_W'(REACQ_PERIOD - 1)) begin
            period_n = '0;
            if (overload) begin
              clean_n = '0;
              if (gain_code != '0) begin
                gain_n    = gain_code - 1'b1;
                changed_n = 1'b1;
              end
            end else if (clean_cnt == CLEAN_W'(UP_HOLDOFF - 1)) begin
              clean_n = '0;
              if (gain_code != GAIN_MAX) begin
                gain_n    = gain_code + 1'b1;
                changed_n = 1'b1;
              end
            end else begin
              clean_n = clean_cnt + 1'b1;
            end
          end else begin
            period_n = period_cnt + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end

`ifdef AGC_TRACK_EN
    // Tracking counters only run in HOLD, so they start from zero on entry.
    if (state_n != HOLD) begin
      period_n = '0;
      clean_n  = '0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state       <= IDLE;
      gain_code   <= '0;
      vga_control <= '0;
      mask        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state       <= state_n;
      gain_code   <= gain_n;
      vga_control <= therm_n;
      mask        <= mask_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

`ifdef AGC_TRACK_EN
  // Tracking period/clean counters and the one-cycle step pulse.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      period_cnt   <= '0;
      clean_cnt    <= '0;
      gain_changed <= 1'b0;
    end else begin
      period_cnt   <= period_n;
      clean_cnt    <= clean_n;
      gain_changed <= changed_n;
    end
  end
`endif

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Directed bench for agc_gain_sequencer. The overload comparator is modelled
// as (gain_code >= target), or tied low. Tracking checks follow AGC_TRACK_EN.
module tb_agc_gain_sequencer;
  import agc_pkg::*;

  localparam int GW = GAIN_W_DEF;
  localparam int TW = THERM_W_DEF;

  logic          clk = 1'b0;
  logic          RESETn, start, overload, ext_mode;
  logic [GW-1:0] ext_gain, gain_code;
  logic [TW-1:0] vga_control;
  logic          busy, done, gain_changed;

  int   target;
  logic tie0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   trials [6] = '{32, 48, 40, 36, 38, 39};

  always #5 clk = ~clk;

  // Comparator model.
  always_comb overload = tie0 ? 1'b0 : (int'(gain_code) >= target);

  agc_gain_sequencer #(.GAIN_W(GW)) dut (
    .clk          (clk),
    .RESETn       (RESETn),
    .start        (start),
    .overload     (overload),
    .ext_mode     (ext_mode),
    .ext_gain     (ext_gain),
    .gain_code    (gain_code),
    .vga_control  (vga_control),
    .busy         (busy),
    .done         (done),
    .gain_changed (gain_changed)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] therm(input int g);
    if (g >= 64) return '1;
    return (64'd1 << g) - 64'd1;
  endfunction

  // One-cycle start pulse; returns 1 ns after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follows a search from just after its start edge until done.
  task automatic wait_done(input string tag, input int exp_gain, input bit chk_trials);
    int n = 0;
    int busy_hi = int'(busy);
    if (chk_trials) check({tag, "_trial0"}, gain_code, trials[0]);
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_hi++;
      if (chk_trials && (n % 4 == 0) && n < 24)
        check({tag, "_trial"}, gain_code, trials[n/4]);
    end
    check({tag, "_latency"}, n, 24);
    check({tag, "_busy_cycles"}, busy_hi, 24);
    check({tag, "_gain"}, gain_code, exp_gain);
    check({tag, "_vga"}, vga_control, therm(exp_gain));
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    RESETn   = 1'b0;
    start    = 1'b0;
    ext_mode = 1'b0;
    ext_gain = '0;
    tie0     = 1'b0;
    target   = 39;
    #1;
    check("rst_gain", gain_code, 0);
    check("rst_vga", vga_control, 0);
    check("rst_flags", {busy, done, gain_changed}, 0);
    repeat (2) @(negedge clk);
    RESETn = 1'b1;

    // 1. Nominal search, target 39 -> 38.
    pulse_start();
    check("s1_busy_start", busy, 1);
    check("s1_done_start", done, 0);
    wait_done("s1", 38, 1'b1);
    check("s1_done", done, 1);

    // 2. Bounds.
    target = 0;
    pulse_start();
    check("s2_restart_from_hold", done, 0);
    wait_done("s2_all_ovl", 0, 1'b0);
    tie0 = 1'b1;
    pulse_start();
    wait_done("s2_no_ovl", 63, 1'b0);
    tie0 = 1'b0;

    // 3a. Restart on the 10th edge of a search.
    target = 39;
    pulse_start();
    repeat (9) @(posedge clk);
    #1;
    check("s3_pre_restart_gain", gain_code, 40);
    pulse_start();
    wait_done("s3_restart", 38, 1'b1);

    // 3b. Asynchronous reset mid-search.
    pulse_start();
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    RESETn = 1'b0;
    #1;
    check("s3_arst_gain", gain_code, 0);
    check("s3_arst_vga", vga_control, 0);
    check("s3_arst_flags", {busy, done, gain_changed}, 0);
    @(negedge clk);
    RESETn = 1'b1;
    @(posedge clk);
    #1;
    check("s3_idle_after_rst", {busy, done}, 0);

    // 4. Manual override mid-search.
    pulse_start();
    repeat (3) @(posedge clk);
    @(negedge clk);
    ext_mode = 1'b1;
    ext_gain = 6'd17;
    @(posedge clk);
    #1;
    check("s4_ext_gain", gain_code, 17);
    check("s4_ext_vga", vga_control, therm(17));
    check("s4_ext_flags", {busy, done}, 0);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s4_start_ignored", {busy, done}, 0);
    check("s4_gain_held", gain_code, 17);
    @(negedge clk);
    start    = 1'b0;
    ext_mode = 1'b0;
    ext_gain = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    check("s4_after_ext_gain", gain_code, 17);
    check("s4_after_ext_flags", {busy, done}, 0);

    // 5. Lock at 38, then the signal drops so target becomes 21.
    pulse_start();
    wait_done("s5_lock", 38, 1'b0);
    target = 21;
`ifdef AGC_TRACK_EN
    begin
      int pulses = 0;
      int last   = 0;
      int cyc    = 0;
      int exp_g;
      int exp_int;
      while (pulses < 20 && cyc < 7000) begin
        @(posedge clk);
        #1;
        cyc++;
        if (gain_changed) begin
          pulses++;
          exp_g   = (pulses <= 18) ? 38 - pulses : ((pulses == 19) ? 21 : 20);
          exp_int = (pulses == 19) ? 1024 : 256;
          check("s5_trk_gain", gain_code, exp_g);
          check("s5_trk_interval", cyc - last, exp_int);
          last = cyc;
        end
      end
      check("s5_trk_pulses", pulses, 20);
      check("s5_trk_done", done, 1);
    end
`else
    begin
      int pulses = 0;
      repeat (600) begin
        @(posedge clk);
        #1;
        if (gain_changed) pulses++;
      end
      check("s5_hold_gain", gain_code, 38);
      check("s5_hold_pulses", pulses, 0);
      check("s5_hold_done", done, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
